// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART transmit scheduler.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    WAIT_BUSY,
    SENDING,
    GAP
  } tx_sched_state_t;

  function automatic int cnt_width(input int a, input int b);
    return $clog2(((a > b) ? a : b) + 1);
  endfunction

endpackage

// File: rtl/uart_rr_arbiter.sv
// Round-robin search: first valid requester at or after ptr, wrapping.
module uart_rr_arbiter #(
  parameter int NUM_REQ = 4,
  localparam int PW = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_valid_i,
  input  logic [PW-1:0]      ptr_i,
  output logic [PW-1:0]      grant_o,
  output logic               any_o
);

  always_comb begin
    int j;
    logic [PW-1:0] jj;
    grant_o = '0;
    any_o   = 1'b0;
    j       = 0;
    jj      = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      j = int'(ptr_i) + k;
      if (j >= NUM_REQ) j = j - NUM_REQ;
      jj = PW'(j);
      if (!any_o && req_valid_i[jj]) begin
        any_o   = 1'b1;
        grant_o = jj;
      end
    end
  end

endmodule

// File: rtl/uart_tx_scheduler.sv
// Shares one UART transmitter between several byte requesters,
// sequencing start, busy confirmation, frame end and a guard gap.
module uart_tx_scheduler
  import uart_pkg::*;
#(
  parameter int NUM_REQ       = 4,
  parameter int DATA_W        = 8,
  parameter int GAP_CYCLES    = 16,
  parameter int START_TIMEOUT = 1024
) (
  input  logic                        clk,
  input  logic                        RST,
  input  logic [NUM_REQ-1:0]          req_valid,
  input  logic [NUM_REQ*DATA_W-1:0]   req_data,
  output logic [NUM_REQ-1:0]          req_ack,
  output logic                        tx_start,
  output logic [DATA_W-1:0]           tx_data,
  input  logic                        tx_busy,
  output logic [$clog2(NUM_REQ)-1:0]  grant_id,
  output logic                        active,
  output logic                        err_timeout
);

  localparam int PW = $clog2(NUM_REQ);
  localparam int CW = cnt_width(START_TIMEOUT, GAP_CYCLES);

  tx_sched_state_t state_q, state_d;
  logic [PW-1:0]     ptr_q, ptr_d;
  logic [PW-1:0]     grant_q, grant_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [CW-1:0]     cnt_q, cnt_d, cnt_inc;
  logic [PW-1:0]     arb_idx;
  logic              any_valid;
  logic              timeout;

  uart_rr_arbiter #(
    .NUM_REQ(NUM_REQ)
  ) u_arb (
    .req_valid_i(req_valid),
    .ptr_i      (ptr_q),
    .grant_o    (arb_idx),
    .any_o      (any_valid)
  );

  assign cnt_inc = (&cnt_q) ? cnt_q : cnt_q + 1'b1;

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    grant_d = grant_q;
    data_d  = data_q;
    cnt_d   = cnt_q;
    timeout = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (any_valid) begin
          grant_d = arb_idx;
          data_d  = req_data[arb_idx*DATA_W +: DATA_W];
          ptr_d   = (int'(arb_idx) == NUM_REQ - 1) ? '0 : arb_idx + 1'b1;
          state_d = START;
        end
      end
      START: begin
        cnt_d   = '0;
        state_d = WAIT_BUSY;
      end
      WAIT_BUSY: begin
        if (tx_busy) begin
          state_d = SENDING;
        end else if (int'(cnt_q) >= START_TIMEOUT - 1) begin
          // byte was already acked, so it is dropped rather than retried
          timeout = 1'b1;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      SENDING: begin
        if (!tx_busy) begin
          cnt_d   = '0;
          state_d = (GAP_CYCLES == 0) ? IDLE : GAP;
        end
      end
      GAP: begin
        if (int'(cnt_q) >= GAP_CYCLES - 1) state_d = IDLE;
        else cnt_d = cnt_inc;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge RST) begin
    if (RST) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      grant_q <= '0;
      data_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      grant_q <= grant_d;
      data_q  <= data_d;
      cnt_q   <= cnt_d;
    end
  end

  assign tx_start    = (state_q == START);
  assign req_ack     = tx_start ? (NUM_REQ'(1) << grant_q) : '0;
  assign tx_data     = data_q;
  assign grant_id    = grant_q;
  assign active      = (state_q != IDLE);
  assign err_timeout = timeout;

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Self-checking bench for uart_tx_scheduler: directed tables,
// corner sequences and a randomized run against a frame-level model.
module tb_uart_tx_scheduler;

  localparam int GAP = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req_valid, req_ack;
  logic [31:0] req_data;
  logic        tx_start, tx_busy, active, err_timeout;
  logic [7:0]  tx_data;
  logic [1:0]  grant_id;

  logic [3:0]  req_valid_z, req_ack_z;
  logic [31:0] req_data_z;
  logic        tx_start_z, tx_busy_z, active_z, err_timeout_z;
  logic [7:0]  tx_data_z;
  logic [1:0]  grant_id_z;

  int n_cmp = 0;
  int n_bad = 0;
  int ack_n [4];

  always #5 clk = ~clk;

  uart_tx_scheduler #(
    .NUM_REQ(4), .DATA_W(8), .GAP_CYCLES(GAP), .START_TIMEOUT(1024)
  ) dut (
    .clk(clk), .RST(rst), .req_valid(req_valid), .req_data(req_data),
    .req_ack(req_ack), .tx_start(tx_start), .tx_data(tx_data),
    .tx_busy(tx_busy), .grant_id(grant_id), .active(active),
    .err_timeout(err_timeout)
  );

  uart_tx_scheduler #(
    .NUM_REQ(4), .DATA_W(8), .GAP_CYCLES(0), .START_TIMEOUT(1024)
  ) dut0 (
    .clk(clk), .RST(rst), .req_valid(req_valid_z), .req_data(req_data_z),
    .req_ack(req_ack_z), .tx_start(tx_start_z), .tx_data(tx_data_z),
    .tx_busy(tx_busy_z), .grant_id(grant_id_z), .active(active_z),
    .err_timeout(err_timeout_z)
  );

  always @(negedge clk)
    for (int i = 0; i < 4; i++) ack_n[i] += int'(req_ack[i]);

  typedef struct {
    logic [3:0]  valid;
    logic [31:0] data;
    logic [1:0]  grant;
    logic [7:0]  txd;
  } vec_t;

  vec_t tbl [8];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  task automatic wait_start(input string nm);
    for (int i = 0; i < 64; i++) begin
      step();
      if (tx_start) return;
    end
    n_cmp++;
    n_bad++;
    $display("FAIL %s: tx_start=0 after 64 cycles, want 1", nm);
  endtask

  task automatic wait_idle(input string nm);
    for (int i = 0; i < 64; i++) begin
      if (!active) return;
      step();
    end
    n_cmp++;
    n_bad++;
    $display("FAIL %s: active=1 after 64 cycles, want 0", nm);
  endtask

  // tx_fsm stand-in: busy rises dly cycles after start, lasts len cycles
  task automatic run_frame(input int dly, input int len);
    repeat (dly) step();
    tx_busy = 1'b1;
    repeat (len) step();
    tx_busy = 1'b0;
  endtask

  function automatic int rr_pick(input logic [3:0] v, input int p);
    for (int k = 0; k < 4; k++)
      if (v[(p + k) % 4]) return (p + k) % 4;
    return -1;
  endfunction

  initial begin
    int hi, k, base, w1;
    int free_at, s_last, bon, boff, err_at, ptr_m, acked, n_to, idx;
    logic [3:0]  rv, ack_e;
    logic [31:0] rd;
    logic [1:0]  eg;
    logic [7:0]  ed;
    logic        exp_st, act_e, err_e, spur;

    tbl[0] = '{4'b1111, 32'h13121110, 2'd0, 8'h10};
    tbl[1] = '{4'b0001, 32'h0000005A, 2'd0, 8'h5A};
    tbl[2] = '{4'b1001, 32'hC3000011, 2'd3, 8'hC3};
    tbl[3] = '{4'b0110, 32'h00E7F000, 2'd1, 8'hF0};
    tbl[4] = '{4'b0011, 32'h00002B1A, 2'd0, 8'h1A};
    tbl[5] = '{4'b1100, 32'h7E3C0000, 2'd2, 8'h3C};
    tbl[6] = '{4'b0100, 32'h00FF0000, 2'd2, 8'hFF};
    tbl[7] = '{4'b0101, 32'h00800001, 2'd0, 8'h01};

    rst = 1'b1;
    req_valid = '0; req_data = '0; tx_busy = 1'b0;
    req_valid_z = '0; req_data_z = '0; tx_busy_z = 1'b0;
    step();
    chk("rst_start", 32'(tx_start), 0);
    chk("rst_ack", 32'(req_ack), 0);
    chk("rst_data", 32'(tx_data), 0);
    chk("rst_grant", 32'(grant_id), 0);
    chk("rst_active", 32'(active), 0);
    chk("rst_err", 32'(err_timeout), 0);
    step();
    rst = 1'b0;

    // single request on requester 2
    req_valid = 4'b0100;
    req_data  = 32'h00A50000;
    step();
    chk("a_start", 32'(tx_start), 1);
    chk("a_ack", 32'(req_ack), 32'h4);
    chk("a_data", 32'(tx_data), 32'hA5);
    chk("a_grant", 32'(grant_id), 2);
    req_valid = '0;
    step();
    chk("a_pulse", 32'({tx_start, req_ack}), 0);
    run_frame(1, 10);
    hi = 0;
    for (int i = 0; i < 40; i++) begin
      step();
      if (!active) break;
      hi++;
    end
    chk("a_gap_active", 32'(hi), GAP);
    chk("a_hold", 32'(tx_data), 32'hA5);

    // asynchronous reset while SENDING
    req_valid = 4'b0001;
    req_data  = 32'h00000077;
    wait_start("r_start");
    req_valid = '0;
    step(); step();
    tx_busy = 1'b1;
    step(); step(); step();
    #3 rst = 1'b1;
    #1;
    chk("r_async", 32'({tx_start, req_ack, tx_data, grant_id, active,
                        err_timeout}), 0);
    tx_busy = 1'b0;
    step();
    rst = 1'b0;
    req_valid = 4'b1000;
    req_data  = 32'h3C000000;
    step();
    chk("r_start3", 32'(tx_start), 1);
    chk("r_grant3", 32'(grant_id), 3);
    req_valid = '0;
    run_frame(2, 3);
    wait_idle("r_idle");

    // arbitration table, pointer starts at 0 after the requester-3 grant
    for (int t = 0; t < 8; t++) begin
      req_valid = tbl[t].valid;
      req_data  = tbl[t].data;
      wait_start("tbl_start");
      chk($sformatf("tbl%0d_grant", t), 32'(grant_id), 32'(tbl[t].grant));
      chk($sformatf("tbl%0d_data", t), 32'(tx_data), 32'(tbl[t].txd));
      chk($sformatf("tbl%0d_ack", t), 32'(req_ack),
          32'(4'b0001 << tbl[t].grant));
      req_valid = '0;
      run_frame(2, 3);
      wait_idle("tbl_idle");
    end

    // all four requesters held valid
    do_reset();
    base = ack_n[0] + ack_n[1] + ack_n[2] + ack_n[3];
    req_valid = 4'b1111;
    req_data  = 32'h13121110;
    for (int f = 0; f < 5; f++) begin
      wait_start("rr_start");
      chk("rr_grant", 32'(grant_id), f % 4);
      chk("rr_data", 32'(tx_data), 32'h10 + f % 4);
      run_frame($urandom_range(1, 3), $urandom_range(2, 6));
    end
    req_valid = '0;
    wait_idle("rr_idle");
    chk("rr_acks", ack_n[0] + ack_n[1] + ack_n[2] + ack_n[3] - base, 5);

    // withdrawal of requester 1 during a frame for requester 0
    do_reset();
    w1 = ack_n[1];
    req_valid = 4'b0001;
    req_data  = 32'h00420055;
    wait_start("w_start");
    req_valid = '0;
    step(); step();
    tx_busy = 1'b1;
    step(); step();
    req_valid = 4'b0010;
    step(); step();
    req_valid = 4'b0000;
    step();
    req_valid = 4'b0100;
    step();
    tx_busy = 1'b0;
    wait_start("w_next");
    chk("w_grant", 32'(grant_id), 2);
    chk("w_data", 32'(tx_data), 32'h42);
    chk("w_noack1", ack_n[1] - w1, 0);
    req_valid = '0;
    run_frame(2, 3);
    wait_idle("w_idle");

    // start timeout with tx_busy held low
    do_reset();
    req_valid = 4'b0011;
    req_data  = 32'h00000B0A;
    wait_start("t_start");
    chk("t_grant0", 32'(grant_id), 0);
    k = 0;
    for (int i = 1; i <= 1100; i++) begin
      step();
      if (err_timeout) begin
        k = i;
        break;
      end
    end
    chk("t_cycles", k, 1024);
    step();
    chk("t_pulse", 32'({err_timeout, active}), 0);
    step();
    chk("t_next_start", 32'(tx_start), 1);
    chk("t_next_grant", 32'(grant_id), 1);
    chk("t_next_data", 32'(tx_data), 32'h0B);
    req_valid = '0;
    run_frame(2, 3);
    wait_idle("t_idle");

    // zero-gap build, back-to-back frames
    req_valid_z = 4'b0011;
    req_data_z  = 32'h0000C1C0;
    step();
    chk("z_start", 32'(tx_start_z), 1);
    chk("z_grant0", 32'(grant_id_z), 0);
    for (int f = 0; f < 2; f++) begin
      step(); step();
      tx_busy_z = 1'b1;
      repeat (3) step();
      tx_busy_z = 1'b0;
      k = 0;
      for (int i = 1; i <= 10; i++) begin
        step();
        if (tx_start_z) begin
          k = i;
          break;
        end
      end
      chk("z_gap", k, 2);
      chk("z_grant", 32'(grant_id_z), (f + 1) % 2);
      chk("z_data", 32'(tx_data_z), 32'hC0 + (f + 1) % 2);
    end
    req_valid_z = '0;
    step(); step();
    tx_busy_z = 1'b1;
    repeat (3) step();
    tx_busy_z = 1'b0;
    step(); step();

    // randomized traffic against a frame-level model
    do_reset();
    free_at = 1; s_last = 1 << 30; bon = -100; boff = -100;
    err_at = -1; ptr_m = 0; acked = -1; n_to = 0;
    eg = '0; ed = '0;
    req_valid = '0;
    for (int m = 1; m <= 4000; m++) begin
      for (int i = 0; i < 4; i++) begin
        if (i == acked) begin
          if ($urandom_range(0, 1) == 1) req_data[i*8 +: 8] = 8'($urandom);
          else req_valid[i] = 1'b0;
        end else if (!req_valid[i]) begin
          if ($urandom_range(0, 3) == 0) begin
            req_valid[i] = 1'b1;
            req_data[i*8 +: 8] = 8'($urandom);
          end
        end else if ($urandom_range(0, 39) == 0) begin
          req_valid[i] = 1'b0;
        end
      end
      spur = ($urandom_range(0, 3) == 0);
      tx_busy = (m >= bon && m < boff) || (spur && m > boff && m <= boff + GAP);
      rv = req_valid;
      rd = req_data;
      step();
      acked = -1;
      exp_st = 1'b0;
      ack_e = '0;
      if (m >= free_at && rv != '0) begin
        idx = rr_pick(rv, ptr_m);
        ptr_m = (idx + 1) % 4;
        eg = 2'(idx);
        ed = rd[idx*8 +: 8];
        acked = idx;
        exp_st = 1'b1;
        ack_e = 4'b0001 << idx;
        s_last = m;
        if (n_to < 3 && $urandom_range(0, 11) == 0) begin
          n_to++;
          err_at = m + 1024;
          free_at = m + 1026;
          bon = -100;
          boff = -100;
        end else begin
          bon = m + $urandom_range(1, 3);
          boff = bon + $urandom_range(2, 6);
          free_at = boff + GAP + 1;
        end
      end
      act_e = (m >= s_last) && (m < free_at - 1);
      err_e = (m == err_at);
      chk($sformatf("rnd_step%0d", m),
          32'({tx_start, req_ack, active, err_timeout, grant_id, tx_data}),
          32'({exp_st, ack_e, act_e, err_e, eg, ed}));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/uart_tx_scheduler.md
Name: uart_tx_scheduler

Overview:
- Shares the single UART transmit FSM (tx_fsm) between NUM_REQ byte requesters using round-robin arbitration.
- Replaces the debounced one-shot start path when multiple on-chip sources must transmit.
- Sequences each frame:
  - latch data,
  - pulse start,
  - confirm the transmitter went busy,
  - wait for the frame to finish,
  - enforce an inter-frame guard gap.
- Detects a transmitter that never accepts a start.

Parameters:
- NUM_REQ, 4, number of requesters (2..8)
- DATA_W, 8, byte width presented to tx_fsm
- GAP_CYCLES, 16, idle clk cycles inserted after tx_busy falls; 0 means no gap
- START_TIMEOUT, 1024, max clk cycles from tx_start to tx_busy rising before abort

Ports:
- clk  input  1  system clock, rising edge
- RST  input  1  reset, asynchronous, active-high
- req_valid  input  NUM_REQ  per-requester byte pending; held with data until ack
- req_data  input  NUM_REQ*DATA_W  flattened; requester i occupies bits [i*DATA_W +: DATA_W]
- req_ack  output  NUM_REQ  one-cycle pulse: requester's byte latched
- tx_start  output  1  one-cycle start pulse to tx_fsm
- tx_data  output  DATA_W  byte to tx_fsm; stable from tx_start until the frame ends
- tx_busy  input  1  tx_fsm frame in progress
- grant_id  output  $clog2(NUM_REQ)  index of the current or last granted requester
- active  output  1  high in every state except IDLE
- err_timeout  output  1  one-cycle pulse on start timeout

Behaviour:
- Reset (async, RST=1):
  - req_ack=0, tx_start=0, tx_data=0, grant_id=0, active=0, err_timeout=0.
  - Round-robin pointer ptr=0; state IDLE; counters 0.
- States: IDLE, START, WAIT_BUSY, SENDING, GAP.
- IDLE:
  - If req_valid has no bits set, stay in IDLE.
  - Otherwise select i = the first set bit searching ptr, ptr+1, ... wrapping mod NUM_REQ.
  - Register tx_data=req_data[i], grant_id=i, ptr=(i+1) mod NUM_REQ; go to START.
- START (exactly one cycle):
  - tx_start=1 and req_ack[i]=1 together.
  - Clear counter; go to WAIT_BUSY.
  - Latency: req_valid sampled high at edge N gives tx_start/req_ack high in cycle N+1.
- WAIT_BUSY:
  - tx_busy=1: go to SENDING.
  - Otherwise increment counter. When counter reaches START_TIMEOUT-1: err_timeout=1 for one cycle, go to IDLE.
  - ptr stays advanced and the byte is not retried; it has already been acked.
- SENDING: hold tx_data. On tx_busy=0, go to GAP, or to IDLE if GAP_CYCLES=0.
- GAP: count exactly GAP_CYCLES cycles, then go to IDLE. New requests wait.
- active=1 in START, WAIT_BUSY, SENDING and GAP.
- Frame-to-frame minimum, tx_busy fall to next tx_start: GAP_CYCLES+2 cycles.
- Requester rules:
  - req_valid may drop before ack (withdraw); that requester is never granted.
  - After its ack, a requester may keep req_valid high for the next byte. Round-robin serves the others first.
  - req_ack never asserts for a requester whose req_valid was low at the IDLE arbitration edge.
- tx_busy high while in IDLE or GAP (spurious) is ignored, with no error. Arbitration still proceeds; the FSM then waits in WAIT_BUSY/SENDING normally.
- Counter width: $clog2(max(START_TIMEOUT, GAP_CYCLES)+1). Saturates rather than wraps.
- Reset mid-operation aborts the frame immediately with no ack or error. tx_fsm is reset by its own reset.

Decomposition:
- Shared package uart_pkg:
  - typedef enum logic[2:0] tx_sched_state_t {IDLE, START, WAIT_BUSY, SENDING, GAP}
  - localparam function for counter width
- One sub-module: uart_rr_arbiter. Combinational: req_valid + ptr -> grant index and any_valid. Keeps the round-robin search isolated and unit-testable.

Test Plan:
- Single request, req_valid[2]=1, req_data byte2=0xA5, tx_busy rising 2 cycles after start and high 10 cycles:
  - Next cycle: req_ack[2] pulse, tx_start pulse, tx_data=0xA5, grant_id=2.
  - active drops exactly 16 cycles after tx_busy falls.
- All four requesters held valid with data 0x10..0x13 and a behavioural tx_fsm model:
  - Grant order 0,1,2,3,0.
  - Each tx_data matches its requester.
  - Exactly one ack per frame.
- Timeout, tx_busy tied 0:
  - err_timeout pulses 1024 cycles after tx_start.
  - FSM returns to IDLE; next grant is the following requester.
- Withdrawal: req_valid[1] raised then dropped while SENDING for requester 0 -> next grant goes to 2; req_ack[1] never asserts.
- Reset mid-SENDING, RST asserted asynchronously between edges:
  - All outputs 0 immediately.
  - After release, with req_valid[3]=1, grant_id=3 and tx_start pulses one cycle later.
- GAP_CYCLES=0 build: back-to-back requests give tx_start 2 cycles after tx_busy falls.
